// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the CPU load/store port
// Byte-enable stores, 1-cycle registered loads, illegal-address flag, write trace.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [3:0]  be,
  output logic [31:0] readdata,
  output logic        rvalid,
  output logic        err,
  output logic [15:0] wr_count,
  output logic [31:0] last_wadr,
  output logic [31:0] last_wdata
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [31:0] last_wadr_q, last_wadr_d;
  logic [31:0] last_wdata_q, last_wdata_d;

  logic [31:0] offset;
  logic        legal;
  logic [AW-1:0] idx;
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic        do_store;
  logic        do_load;

  // Checking the byte offset against the byte span avoids a wrap for addresses below BASE_ADDR
  // only together with the explicit lower-bound compare.
  always_comb begin
    offset   = dataadr - BASE_ADDR;
    legal    = (dataadr >= BASE_ADDR) && (offset < SPAN);
    idx      = offset[AW+1:2];
    cur_word = mem_q[idx];
    do_store = req && memwrite && legal && !rst;
    do_load  = req && !memwrite && legal && !rst;
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = be[i] ? writedata[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  always_comb begin
    readdata_d   = readdata_q;
    rvalid_d     = 1'b0;
    err_d        = req && !legal;
    wr_count_d   = wr_count_q;
    last_wadr_d  = last_wadr_q;
    last_wdata_d = last_wdata_q;
    if (do_load) begin
      readdata_d = cur_word;
      rvalid_d   = 1'b1;
    end
    if (do_store) begin
      wr_count_d   = wr_count_q + 16'd1;
      last_wadr_d  = dataadr;
      last_wdata_d = merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdata_q   <= 32'h0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      wr_count_q   <= 16'h0;
      last_wadr_q  <= 32'h0;
      last_wdata_q <= 32'h0;
    end else begin
      readdata_q   <= readdata_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      wr_count_q   <= wr_count_d;
      last_wadr_q  <= last_wadr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  // RAM contents survive reset; do_store is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem_q[idx] <= merged_word;
    end
  end

  assign readdata   = readdata_q;
  assign rvalid     = rvalid_q;
  assign err        = err_q;
  assign wr_count   = wr_count_q;
  assign last_wadr  = last_wadr_q;
  assign last_wdata = last_wdata_q;

endmodule
